// File: rtl/mux4.sv
// Four-way data selector with a combinational output and an enabled,
// registered copy that flags validity and value changes.
module mux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_q,
    output logic             z_vld,
    output logic             z_chg
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("mux4: WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             vld_d;
    logic             vld_q;
    logic             chg_d;
    logic             chg_q;

    // An unknown select falls through to the default so X reaches z.
    always_comb begin
        z = 'x;
        case (sel)
            2'b00:   z = d0;
            2'b01:   z = d1;
            2'b10:   z = d2;
            2'b11:   z = d3;
            default: z = 'x;
        endcase
    end

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        chg_d  = 1'b0;
        if (en) begin
            data_d = z;
            vld_d  = 1'b1;
            chg_d  = (z != data_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            chg_q  <= chg_d;
        end
    end

    assign z_q   = data_q;
    assign z_vld = vld_q;
    assign z_chg = chg_q;

endmodule

// File: tb/tb_mux4.sv
// Directed bench for mux4: literal checks plus a per-cycle reference model
// built from array indexing and a last-value register.
module tb_mux4;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din [4];
    logic [1:0]   sel;
    logic         en;
    logic [W-1:0] z;
    logic [W-1:0] z_q;
    logic         z_vld;
    logic         z_chg;

    int errors = 0;
    int checks = 0;
    bit run = 0;

    logic [W-1:0] m_q;
    logic         m_vld;
    logic         m_chg;

    mux4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (din[0]),
        .d1    (din[1]),
        .d2    (din[2]),
        .d3    (din[3]),
        .sel   (sel),
        .en    (en),
        .z     (z),
        .z_q   (z_q),
        .z_vld (z_vld),
        .z_chg (z_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: selected value is a table lookup; the register side
    // remembers the last captured value and notes whether it moved.
    always @(negedge rst_n) begin
        m_q   = '0;
        m_vld = 1'b0;
        m_chg = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (en) begin
                m_chg = (din[sel] != m_q);
                m_q   = din[sel];
                m_vld = 1'b1;
            end else begin
                m_chg = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("model_z", 32'(z), 32'(din[sel]));
            check("model_z_q", 32'(z_q), 32'(m_q));
            check("model_z_vld", 32'(z_vld), 32'(m_vld));
            check("model_z_chg", 32'(z_chg), 32'(m_chg));
        end
    end

    task automatic set_all(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
        din[0] = a;
        din[1] = b;
        din[2] = c;
        din[3] = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 2'b00;
        set_all(0, 0, 0, 0);

        #50;
        check("idle_z0", 32'(z), 32'h0);
        din[0] = 1;
        #1 check("d0_rise_z", 32'(z), 32'h1);
        din[0] = 0;
        #1 check("d0_fall_z", 32'(z), 32'h0);

        for (int hot = 0; hot < 4; hot++) begin
            for (int s = 0; s < 4; s++) begin
                set_all(0, 0, 0, 0);
                din[hot] = 1;
                sel = 2'(s);
                #1 check("onehot_walk", 32'(z), (s == hot) ? 32'h1 : 32'h0);
            end
        end

        sel = 2'b01;
        set_all(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            din[0] = 4'hF;
            #1 check("unsel_d0", 32'(z), 32'h0);
            din[2] = 4'hF;
            #1 check("unsel_d2", 32'(z), 32'h0);
            din[3] = 4'hF;
            #1 check("unsel_d3", 32'(z), 32'h0);
            set_all(0, 0, 0, 0);
            #1;
        end

        set_all(4'h3, 4'h5, 4'hA, 4'hC);
        sel = 2'b10;
        #1 check("bitpar_d2", 32'(z), 32'hA);
        sel = 2'b11;
        #1 check("bitpar_d3", 32'(z), 32'hC);

        en = 1'b1;
        tick();
        check("rst_hold_zq", 32'(z_q), 32'h0);
        check("rst_hold_vld", 32'(z_vld), 32'h0);
        check("rst_hold_chg", 32'(z_chg), 32'h0);

        rst_n = 1'b1;
        set_all(1, 0, 0, 0);
        sel = 2'b00;
        en  = 1'b1;
        run = 1;
        tick();
        check("cap1_zq", 32'(z_q), 32'h1);
        check("cap1_vld", 32'(z_vld), 32'h1);
        check("cap1_chg", 32'(z_chg), 32'h1);
        tick();
        check("same_zq", 32'(z_q), 32'h1);
        check("same_chg", 32'(z_chg), 32'h0);

        en = 1'b0;
        din[0] = 4'h3;
        tick();
        check("hold_zq", 32'(z_q), 32'h1);
        check("hold_chg", 32'(z_chg), 32'h0);
        check("hold_vld", 32'(z_vld), 32'h1);

        en = 1'b1;
        tick();
        check("cap3_zq", 32'(z_q), 32'h3);
        check("cap3_chg", 32'(z_chg), 32'h1);

        sel = 2'b11;
        din[3] = 4'h0;
        tick();
        check("cap0_zq", 32'(z_q), 32'h0);
        check("cap0_chg", 32'(z_chg), 32'h1);

        din[3] = 4'h7;
        tick();
        check("cap7_zq", 32'(z_q), 32'h7);
        check("cap7_chg", 32'(z_chg), 32'h1);

        #2 rst_n = 1'b0;
        #1;
        check("async_rst_zq", 32'(z_q), 32'h0);
        check("async_rst_vld", 32'(z_vld), 32'h0);
        check("async_rst_chg", 32'(z_chg), 32'h0);
        din[3] = 4'h9;
        #1 check("rst_comb_z", 32'(z), 32'h9);

        tick();
        rst_n = 1'b1;
        din[3] = 4'h0;
        tick();
        check("first_zero_vld", 32'(z_vld), 32'h1);
        check("first_zero_chg", 32'(z_chg), 32'h0);

        for (int i = 0; i < 24; i++) begin
            set_all(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            sel = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 3) != 0);
            if (i % 5 == 4) din[sel] = z_q;
            tick();
        end

        @(negedge clk);
        #1;
        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4.md
MUX4 -- requirements
Module: mux4

Interface
- REQ-001 Parameter WIDTH, default 1: width in bits of each data input and of each data output.
- REQ-002 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
- REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-004 Port d0, input, WIDTH bits: data input selected when sel=2'b00.
- REQ-005 Port d1, input, WIDTH bits: data input selected when sel=2'b01.
- REQ-006 Port d2, input, WIDTH bits: data input selected when sel=2'b10.
- REQ-007 Port d3, input, WIDTH bits: data input selected when sel=2'b11.
- REQ-008 Port sel, input, 2 bits: select code.
- REQ-009 Port en, input, 1 bit: capture enable for the registered path.
- REQ-010 Port z, output, WIDTH bits: combinational selected data.
- REQ-011 Port z_q, output, WIDTH bits: registered copy of z.
- REQ-012 Port z_vld, output, 1 bit: z_q holds a value captured since the last reset.
- REQ-013 Port z_chg, output, 1 bit: one-cycle pulse when the last capture changed z_q.

Function
- REQ-014 z SHALL equal d0, d1, d2 or d3 for sel = 00, 01, 10 or 11 respectively, with zero clock latency.
- REQ-015 z SHALL be purely combinational and SHALL follow any change on sel or on the selected data input within the same delta/time step, with no clock required.
- REQ-016 A change on a non-selected data input SHALL NOT affect z.
- REQ-017 If sel contains X or Z, z SHALL be X in simulation; no X-pessimism masking SHALL be applied.
- REQ-018 On a rising clk edge with en=1 and rst_n=1, z_q SHALL load the value of z, giving one cycle of latency from the inputs to z_q.
- REQ-019 On a rising clk edge with en=0, z_q, z_vld and z_chg-source state SHALL hold their values, and z_chg SHALL be 0 in the following cycle.
- REQ-020 z_vld SHALL go to 1 on the first capture (en=1) after reset and SHALL stay at 1 until the next reset.
- REQ-021 z_chg SHALL be 1 for exactly the cycle after a capture whose loaded value differs from the previous z_q, and 0 otherwise.
- REQ-022 The first capture after reset SHALL assert z_chg if the captured value is non-zero.
- REQ-023 All paths SHALL be bit-parallel: each bit i of z SHALL be taken from bit i of the selected input, with no width extension or truncation.
- REQ-024 WIDTH < 1 SHALL be rejected by an elaboration-time error.

Reset
- REQ-025 Asserting rst_n=0 SHALL immediately, without waiting for a clock, force z_q=0, z_vld=0 and z_chg=0.
- REQ-026 While rst_n=0, z SHALL remain functional (combinational) and captures SHALL be inhibited.
- REQ-027 After rst_n is deasserted, the first rising edge SHALL behave per REQ-018..REQ-022.
- REQ-028 Reset asserted in the middle of operation SHALL discard any pending z_chg pulse.

Verification
- REQ-029 All data inputs = 0, sel=00, hold 50 time units -> z=0; then d0=1 -> z=1 with no clock edge; then d0=0 -> z=0.
- REQ-030 Walk sel through 00..11 with d0..d3 = 1,0,0,0 and then one-hot rotated -> z=1 only when sel matches the hot input.
- REQ-031 sel=01 with d1 held at 0, toggle d0, d2 and d3 -> z stays 0.
- REQ-032 Reset, then en=1 with z=1 for one edge -> next cycle z_q=1, z_vld=1, z_chg=1; next edge with the same value -> z_chg=0.
- REQ-033 en=0 while the inputs change -> z_q holds and z_chg=0.
- REQ-034 rst_n pulled low between clock edges while z_q=1 -> z_q=0, z_vld=0 and z_chg=0 immediately.
